instr_register_mc: RTL and testbench



---
 rtl/instr_register_mc_if.sv | 33 +++
 rtl/instr_register_mc.sv | 192 +++++++++++++++++++
 tb/tb_instr_register_mc.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_register_mc_if.sv
// Bundled write/read/status signals between the stimulus front-end and instr_register_mc.
interface instr_register_mc_if #(
   parameter int unsigned OP_WIDTH = 32,
   parameter int unsigned DEPTH    = 32
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                    load_valid;
   logic                    load_ready;
   logic [3:0]              opcode;
   logic [OP_WIDTH-1:0]     operand_a;
   logic [OP_WIDTH-1:0]     operand_b;
   logic [AW-1:0]           write_pointer;
   logic                    read_en;
   logic [AW-1:0]           read_pointer;
   logic                    rd_valid;
   logic [3:0]              rd_opcode;
   logic [OP_WIDTH-1:0]     rd_operand_a;
   logic [OP_WIDTH-1:0]     rd_operand_b;
   logic [2*OP_WIDTH-1:0]   rd_result;
   logic                    rd_err;
   logic                    done;

   modport master (
      output load_valid, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
      input  load_ready, rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, done
   );

   modport slave (
      input  load_valid, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
      output load_ready, rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, done
   );
endinterface

// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: DEPTH entries with computed results, iterative DIV/MOD,
// valid/ready write port and a registered 1-cycle-latency read port.
module instr_register_mc #(
   parameter int unsigned OP_WIDTH = 32,
   parameter int unsigned DEPTH    = 32
) (
   input  logic               clk,
   input  logic               reset,
   instr_register_mc_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned RW = 2 * OP_WIDTH;
   localparam int unsigned CW = $clog2(OP_WIDTH);

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;

   typedef struct packed {
      logic [3:0]          opcode;
      logic [OP_WIDTH-1:0] operand_a;
      logic [OP_WIDTH-1:0] operand_b;
      logic [RW-1:0]       result;
      logic                err;
   } entry_t;

   entry_t              mem [DEPTH];
   logic [1:0]          state_q, state_d;
   logic                load_ready_q;
   logic                done_q;
   logic                rd_valid_q;
   entry_t              rd_q;

   logic [OP_WIDTH-1:0] div_q, div_r, div_b;
   logic [CW-1:0]       div_cnt;
   logic                neg_q, neg_r;
   logic [3:0]          cap_opcode;
   logic [OP_WIDTH-1:0] cap_a, cap_b;
   logic [AW-1:0]       cap_wp;

   logic                accept_c, is_div_c, we_c, start_div_c;
   logic signed [RW-1:0] a_ext_c, b_ext_c;
   logic [RW-1:0]       alu_c;
   logic [OP_WIDTH-1:0] abs_a_c, abs_b_c;
   logic [OP_WIDTH:0]   shifted_c, trial_c;
   logic [RW-1:0]       q_ext_c, r_ext_c, div_res_c;
   logic [AW-1:0]       wr_ptr_c;
   entry_t              wr_entry_c;

   assign accept_c = bus.load_valid && load_ready_q;
   assign is_div_c = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
   assign a_ext_c  = {{OP_WIDTH{bus.operand_a[OP_WIDTH-1]}}, bus.operand_a};
   assign b_ext_c  = {{OP_WIDTH{bus.operand_b[OP_WIDTH-1]}}, bus.operand_b};
   assign abs_a_c  = bus.operand_a[OP_WIDTH-1] ? -bus.operand_a : bus.operand_a;
   assign abs_b_c  = bus.operand_b[OP_WIDTH-1] ? -bus.operand_b : bus.operand_b;

   // Single-cycle results; DIV/MOD only reach here when the divisor is zero.
   always_comb begin
      alu_c = '0;
      case (bus.opcode)
         OP_ZERO:  alu_c = '0;
         OP_PASSA: alu_c = a_ext_c;
         OP_PASSB: alu_c = b_ext_c;
         OP_ADD:   alu_c = a_ext_c + b_ext_c;
         OP_SUB:   alu_c = a_ext_c - b_ext_c;
         OP_MULT:  alu_c = a_ext_c * b_ext_c;
         default:  alu_c = '0;
      endcase
   end

   // One restoring step on magnitudes; partial remainder never exceeds the divisor.
   assign shifted_c = {div_r, div_q[OP_WIDTH-1]};
   assign trial_c   = shifted_c - {1'b0, div_b};

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign q_ext_c   = {{OP_WIDTH{1'b0}}, div_q};
   assign r_ext_c   = {{OP_WIDTH{1'b0}}, div_r};
   assign div_res_c = (cap_opcode == OP_DIV) ? (neg_q ? -q_ext_c : q_ext_c)
                                             : (neg_r ? -r_ext_c : r_ext_c);

   always_comb begin
      state_d               = state_q;
      we_c                  = 1'b0;
      start_div_c           = 1'b0;
      wr_ptr_c              = bus.write_pointer;
      wr_entry_c.opcode     = bus.opcode;
      wr_entry_c.operand_a  = bus.operand_a;
      wr_entry_c.operand_b  = bus.operand_b;
      wr_entry_c.result     = alu_c;
      wr_entry_c.err        = is_div_c;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (is_div_c && (bus.operand_b != '0)) begin
                  state_d     = S_DIVIDE;
                  start_div_c = 1'b1;
               end else begin
                  we_c = 1'b1;
               end
            end
         end
         S_DIVIDE: begin
            if (div_cnt == CW'(OP_WIDTH - 1)) state_d = S_WRITE;
         end
         S_WRITE: begin
            we_c                 = 1'b1;
            wr_ptr_c             = cap_wp;
            wr_entry_c.opcode    = cap_opcode;
            wr_entry_c.operand_a = cap_a;
            wr_entry_c.operand_b = cap_b;
            wr_entry_c.result    = div_res_c;
            wr_entry_c.err       = 1'b0;
            state_d              = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         load_ready_q <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ready_q <= (state_d == S_IDLE);
         done_q       <= we_c;
      end
   end

   // Divider datapath and captured request; only meaningful while the FSM is busy.
   always_ff @(posedge clk) begin
      if (start_div_c) begin
         div_q      <= abs_a_c;
         div_r      <= '0;
         div_b      <= abs_b_c;
         div_cnt    <= '0;
         neg_q      <= bus.operand_a[OP_WIDTH-1] ^ bus.operand_b[OP_WIDTH-1];
         neg_r      <= bus.operand_a[OP_WIDTH-1];
         cap_opcode <= bus.opcode;
         cap_a      <= bus.operand_a;
         cap_b      <= bus.operand_b;
         cap_wp     <= bus.write_pointer;
      end else if (state_q == S_DIVIDE) begin
         div_cnt <= div_cnt + CW'(1);
         if (!trial_c[OP_WIDTH]) begin
            div_r <= trial_c[OP_WIDTH-1:0];
            div_q <= {div_q[OP_WIDTH-2:0], 1'b1};
         end else begin
            div_r <= shifted_c[OP_WIDTH-1:0];
            div_q <= {div_q[OP_WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
      end else if (we_c) begin
         mem[wr_ptr_c] <= wr_entry_c;
      end
   end

   // Read samples the pre-edge array, so a same-edge write is not visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         rd_valid_q <= bus.read_en;
         if (bus.read_en) rd_q <= mem[bus.read_pointer];
      end
   end

   assign bus.load_ready   = load_ready_q;
   assign bus.done         = done_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_opcode    = rd_q.opcode;
   assign bus.rd_operand_a = rd_q.operand_a;
   assign bus.rd_operand_b = rd_q.operand_b;
   assign bus.rd_result    = rd_q.result;
   assign bus.rd_err       = rd_q.err;
endmodule

// File: tb/tb_instr_register_mc.sv
// Scoreboard bench for instr_register_mc: directed corner cases plus randomized traffic.
module tb_instr_register_mc;
   localparam int OPW = 32;
   localparam int DEP = 32;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      logic        err;
   } ent_t;

   typedef struct {
      ent_t e;
      int   c;
   } rdexp_t;

   logic clk;
   logic reset;
   instr_register_mc_if #(.OP_WIDTH(OPW), .DEPTH(DEP)) bus ();
   instr_register_mc #(.OP_WIDTH(OPW), .DEPTH(DEP)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int     vec = 0;
   int     errs = 0;
   int     cyc = 0;
   bit     started = 0;
   bit     rand_reads = 0;
   ent_t   mdl [DEP];
   int     dq [$];
   rdexp_t rq [$];
   bit     pend_valid = 0;
   int     pend_edge;
   int     pend_ptr;
   ent_t   pend_ent;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour straight from the arithmetic rules, in 64-bit signed math.
   function automatic ent_t ref_entry(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      ent_t   e;
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1:    r = sa;
         4'd2:    r = sb;
         4'd3:    r = sa + sb;
         4'd4:    r = sa - sb;
         4'd5:    r = sa * sb;
         4'd6:    r = (sb == 0) ? 0 : sa / sb;
         4'd7:    r = (sb == 0) ? 0 : sa % sb;
         default: r = 0;
      endcase
      e.op  = op;
      e.a   = a;
      e.b   = b;
      e.res = r;
      e.err = ((op == 4'd6) || (op == 4'd7)) && (b == 0);
      return e;
   endfunction

   task automatic issue_read(input logic [4:0] rp);
      rdexp_t x;
      bus.read_en      = 1'b1;
      bus.read_pointer = rp;
      x.e = mdl[rp];
      x.c = cyc + 1;
      rq.push_back(x);
   endtask

   task automatic tick();
      if (rand_reads && !bus.read_en && ($urandom_range(1, 0) == 1))
         issue_read(5'($urandom_range(DEP - 1, 0)));
      @(posedge clk);
      cyc++;
      if (pend_valid && (pend_edge == cyc)) begin
         mdl[pend_ptr] = pend_ent;
         pend_valid    = 0;
      end
      #1;
      bus.read_en = 1'b0;
   endtask

   task automatic do_reset();
      pend_valid = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < DEP; i++) mdl[i] = '0;
      dq.delete();
      rq.delete();
   endtask

   task automatic do_write(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wp, output int acc_edge);
      bit ok = 0;
      ent_t e;
      bus.load_valid    = 1'b1;
      bus.opcode        = op;
      bus.operand_a     = a;
      bus.operand_b     = b;
      bus.write_pointer = wp;
      for (int k = 0; k < 100; k++) begin
         logic rdy;
         rdy = bus.load_ready;
         tick();
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      bus.load_valid = 1'b0;
      acc_edge = cyc;
      if (!ok) begin
         chk("write_accept_timeout", 0, 1);
         return;
      end
      e = ref_entry(op, a, b);
      if (((op == 4'd6) || (op == 4'd7)) && (b != 0)) begin
         pend_valid = 1;
         pend_edge  = cyc + OPW + 1;
         pend_ptr   = wp;
         pend_ent   = e;
         dq.push_back(cyc + OPW + 1);
      end else begin
         mdl[wp] = e;
         dq.push_back(cyc);
      end
   endtask

   task automatic read_expect(input logic [4:0] rp, input logic [63:0] res, input logic err);
      issue_read(rp);
      tick();
      chk("rd_result_const", bus.rd_result, res);
      chk("rd_err_const", bus.rd_err, err);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(7, 0))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: done pulses and read responses checked against scheduled expectations.
   always @(negedge clk) begin
      if (started) begin
         bit exp_done, exp_rd;
         exp_done = (dq.size() > 0) && (dq[0] == cyc);
         if (exp_done || bus.done) chk("done", bus.done, exp_done);
         if (exp_done) void'(dq.pop_front());
         exp_rd = (rq.size() > 0) && (rq[0].c == cyc);
         if (exp_rd || bus.rd_valid) chk("rd_valid", bus.rd_valid, exp_rd);
         if (exp_rd) begin
            chk("rd_fields", {bus.rd_opcode, bus.rd_operand_a, bus.rd_operand_b, bus.rd_err},
                {rq[0].e.op, rq[0].e.a, rq[0].e.b, rq[0].e.err});
            chk("rd_result", bus.rd_result, rq[0].e.res);
            void'(rq.pop_front());
         end
      end
   end

   initial begin
      int e1, e2, prev, cnt;
      reset = 1'b1;
      bus.load_valid = 1'b0;
      bus.opcode = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.write_pointer = '0;
      bus.read_en = 1'b0;
      bus.read_pointer = '0;
      do_reset();
      started = 1;
      chk("reset_load_ready", bus.load_ready, 1);
      chk("reset_rd_valid", bus.rd_valid, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_rd_result", bus.rd_result, 0);

      // Reset clears previously written entries.
      for (int i = 1; i <= 3; i++) do_write(4'd3, $urandom, $urandom, 5'(i), e1);
      tick();
      do_reset();
      for (int i = 0; i < DEP; i++) begin
         issue_read(5'(i));
         tick();
      end

      // Directed arithmetic.
      do_write(4'd3, -32'sd5, 32'sd7, 5'd3, e1);
      read_expect(5'd3, 64'd2, 1'b0);
      do_write(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6, e1);
      read_expect(5'd6, 64'h3FFF_FFFF_0000_0001, 1'b0);

      do_write(4'd6, -32'sd7, 32'sd2, 5'd4, e1);
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.load_ready) break;
         cnt++;
         tick();
      end
      chk("div_busy_cycles", cnt, OPW + 1);
      tick();
      read_expect(5'd4, -64'sd3, 1'b0);
      do_write(4'd7, -32'sd7, 32'sd2, 5'd4, e1);
      repeat (OPW + 3) tick();
      read_expect(5'd4, -64'sd1, 1'b0);

      do_write(4'd6, 32'd9, 32'd0, 5'd8, e1);
      chk("div0_ready_stays", bus.load_ready, 1);
      read_expect(5'd8, 64'd0, 1'b1);

      do_write(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, e1);
      repeat (OPW + 3) tick();
      read_expect(5'd12, 64'h0000_0000_8000_0000, 1'b0);

      // Back-to-back single-cycle writes then full read-back.
      prev = 0;
      for (int i = 0; i < DEP; i++) begin
         do_write(4'd3, $urandom, $urandom, 5'(i), e1);
         if (i > 0) chk("b2b_accept_edge", e1, prev + 1);
         prev = e1;
      end
      for (int i = 0; i < DEP; i++) begin
         issue_read(5'(i));
         tick();
      end

      // Request held while divider is busy is accepted exactly once when ready returns.
      do_write(4'd6, 32'd100, 32'd7, 5'd10, e1);
      do_write(4'd3, 32'd1, 32'd2, 5'd11, e2);
      chk("held_accept_edge", e2, e1 + OPW + 2);
      repeat (3) tick();

      // Reset during a divide aborts it.
      do_write(4'd6, $urandom, $urandom | 32'h1, 5'd9, e1);
      repeat (10) tick();
      do_reset();
      chk("abort_load_ready", bus.load_ready, 1);
      issue_read(5'd9);
      tick();

      // Same-edge read and write to one entry returns the old contents.
      do_write(4'd3, 32'd11, 32'd22, 5'd5, e1);
      issue_read(5'd5);
      do_write(4'd4, 32'd100, 32'd1, 5'd5, e1);
      chk("rbw_old_value", bus.rd_result, 64'd33);
      read_expect(5'd5, 64'd99, 1'b0);

      // Randomized traffic with concurrent reads, including during divides.
      rand_reads = 1;
      for (int n = 0; n < 150; n++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 8)) : 4'($urandom_range(7, 0));
         a  = rnd_operand();
         b  = rnd_operand();
         do_write(op, a, b, 5'($urandom_range(DEP - 1, 0)), e1);
         if ($urandom_range(3, 0) == 0) tick();
      end
      rand_reads = 0;
      repeat (OPW + 6) tick();
      for (int i = 0; i < DEP; i++) begin
         issue_read(5'(i));
         tick();
      end
      repeat (3) tick();
      chk("done_queue_drained", dq.size(), 0);
      chk("read_queue_drained", rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
